// File: rtl/pulse_period_checker.sv
// Receive-side pulse checker: measures rising-edge intervals, locks after LOCK_CNT matches, flags early/late pulses.
// Optional macro PULSE_CHK_TOLERANCE_EN widens the match window to PERIOD +/- TOL.
module pulse_period_checker #(
    parameter int PERIOD   = 22,
    parameter int LOCK_CNT = 3,
    parameter int TOL      = 1,
    parameter int CW       = $clog2(2*PERIOD+2)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pulse_in,
    output logic          locked,
    output logic          err_early,
    output logic          err_late,
    output logic [15:0]   err_count,
    output logic [CW-1:0] last_period
);

`ifdef PULSE_CHK_TOLERANCE_EN
    localparam int LO = PERIOD - TOL;
    localparam int HI = PERIOD + TOL;
`else
    localparam int LO = PERIOD;
    localparam int HI = PERIOD + 0*TOL;
`endif
    localparam int MW = $clog2(LOCK_CNT+1);

    typedef enum logic [1:0] {IDLE, ACQ, LOCKED} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [MW-1:0] match_cnt;
    logic          prev_in;

    logic          edge_det, in_win, too_early, late_pt, timeout;
    logic [CW-1:0] cnt_inc;
    logic [15:0]   err_inc;

    always_comb begin
        edge_det  = pulse_in & ~prev_in;
        in_win    = (cnt >= CW'(LO)) && (cnt <= CW'(HI));
        too_early = cnt < CW'(LO);
        late_pt   = cnt == CW'(HI);
        timeout   = cnt == CW'(2*PERIOD);
        cnt_inc   = (cnt == '1) ? cnt : cnt + 1'b1;
        err_inc   = (err_count == 16'hFFFF) ? err_count : err_count + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            match_cnt   <= '0;
            prev_in     <= 1'b0;
            locked      <= 1'b0;
            err_early   <= 1'b0;
            err_late    <= 1'b0;
            err_count   <= '0;
            last_period <= '0;
        end else begin
            prev_in   <= pulse_in;
            err_early <= 1'b0;
            err_late  <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (edge_det) begin
                        state     <= ACQ;
                        match_cnt <= '0;
                        cnt       <= CW'(1);
                    end
                end
                ACQ: begin
                    if (edge_det) begin
                        cnt         <= CW'(1);
                        last_period <= cnt;
                        if (!in_win) begin
                            match_cnt <= '0;
                        end else if (match_cnt == MW'(LOCK_CNT-1)) begin
                            state     <= LOCKED;
                            locked    <= 1'b1;
                            match_cnt <= '0;
                        end else begin
                            match_cnt <= match_cnt + 1'b1;
                        end
                    end else if (timeout) begin
                        // Reference edge went stale; wait for a fresh one
                        state     <= IDLE;
                        cnt       <= '0;
                        match_cnt <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                LOCKED: begin
                    // cnt can never pass HI here: the late check fires at HI first
                    if (edge_det) begin
                        last_period <= cnt;
                        cnt         <= CW'(1);
                        if (too_early) begin
                            err_early <= 1'b1;
                            err_count <= err_inc;
                            locked    <= 1'b0;
                            state     <= IDLE;
                            cnt       <= '0;
                        end
                    end else if (late_pt) begin
                        err_late  <= 1'b1;
                        err_count <= err_inc;
                        locked    <= 1'b0;
                        state     <= IDLE;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: begin
                    state  <= IDLE;
                    cnt    <= '0;
                    locked <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_period_checker.sv
// Directed bench for pulse_period_checker with default parameters (PERIOD=22, LOCK_CNT=3).
module tb_pulse_period_checker;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pulse_in = 1'b0;
    logic        locked, err_early, err_late;
    logic [15:0] err_count;
    logic [5:0]  last_period;

    int total = 0;
    int bad = 0;
    int strobes = 0;
    logic        snap_lk, snap_ee, snap_el;
    logic [5:0]  snap_lp;
    logic [15:0] snap_ec;

    pulse_period_checker dut (
        .clk(clk), .rst(rst), .pulse_in(pulse_in), .locked(locked),
        .err_early(err_early), .err_late(err_late), .err_count(err_count),
        .last_period(last_period)
    );

    always #5 clk = ~clk;

    task automatic step(input logic p);
        pulse_in = p;
        @(posedge clk);
        #1;
        if (err_early | err_late) strobes++;
    endtask

    // Edge cycle followed by (w-1) more high cycles and low cycles to fill iv
    task automatic period(input int w, input int iv);
        step(1'b1);
        snap_lk = locked; snap_ee = err_early; snap_el = err_late;
        snap_lp = last_period; snap_ec = err_count;
        repeat (w-1) step(1'b1);
        repeat (iv-w) step(1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0);
        step(1'b0);
        rst = 1'b0;
        strobes = 0;
    endtask

    // Ends just after the locking edge; next cycle cnt=1
    task automatic lock_up();
        do_reset();
        repeat (3) period(1, 22);
        step(1'b1);
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL reset_locked got=%0d want=0", locked); end
        total++; if ({err_early, err_late} !== 2'b00) begin bad++; $display("FAIL reset_strobes got=%b want=00", {err_early, err_late}); end
        total++; if (err_count !== 16'd0) begin bad++; $display("FAIL reset_err_count got=%0d want=0", err_count); end
        total++; if (last_period !== 6'd0) begin bad++; $display("FAIL reset_last_period got=%0d want=0", last_period); end
    endtask

    task automatic test_lock();
        do_reset();
        period(1, 22);
        total++; if (snap_lp !== 6'd0) begin bad++; $display("FAIL lock_ref_no_lp got=%0d want=0", snap_lp); end
        period(1, 22);
        period(1, 22);
        total++; if (snap_lk !== 1'b0) begin bad++; $display("FAIL lock_early_lock got=%0d want=0", snap_lk); end
        period(1, 22);
        total++; if (snap_lk !== 1'b1) begin bad++; $display("FAIL lock_4th_edge got=%0d want=1", snap_lk); end
        total++; if (snap_lp !== 6'd22) begin bad++; $display("FAIL lock_last_period got=%0d want=22", snap_lp); end
        period(1, 22);
        total++; if (snap_lk !== 1'b1) begin bad++; $display("FAIL lock_5th_edge got=%0d want=1", snap_lk); end
        total++; if (err_count !== 16'd0 || strobes != 0) begin bad++; $display("FAIL lock_no_err got=%0d/%0d want=0/0", err_count, strobes); end
    endtask

    task automatic test_early();
        lock_up();
        repeat (19) step(1'b0);
        period(1, 22);
        total++; if (snap_ee !== 1'b1 || snap_el !== 1'b0) begin bad++; $display("FAIL early_strobe got=%b%b want=10", snap_ee, snap_el); end
        total++; if (snap_lk !== 1'b0) begin bad++; $display("FAIL early_unlock got=%0d want=0", snap_lk); end
        total++; if (snap_lp !== 6'd20) begin bad++; $display("FAIL early_last_period got=%0d want=20", snap_lp); end
        total++; if (snap_ec !== 16'd1) begin bad++; $display("FAIL early_err_count got=%0d want=1", snap_ec); end
        total++; if (strobes != 1) begin bad++; $display("FAIL early_one_cycle got=%0d want=1", strobes); end
        repeat (3) period(1, 22);
        total++; if (snap_lk !== 1'b0) begin bad++; $display("FAIL early_relock_soon got=%0d want=0", snap_lk); end
        period(1, 22);
        total++; if (snap_lk !== 1'b1) begin bad++; $display("FAIL early_relock got=%0d want=1", snap_lk); end
        total++; if (err_count !== 16'd1) begin bad++; $display("FAIL early_count_hold got=%0d want=1", err_count); end
    endtask

    task automatic test_late();
        lock_up();
        repeat (21) step(1'b0);
        total++; if (err_late !== 1'b0 || locked !== 1'b1) begin bad++; $display("FAIL late_premature got=%b%b want=01", err_late, locked); end
        step(1'b0);
        total++; if (err_late !== 1'b1 || err_early !== 1'b0) begin bad++; $display("FAIL late_strobe got=%b%b want=10", err_late, err_early); end
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL late_unlock got=%0d want=0", locked); end
        total++; if (err_count !== 16'd1) begin bad++; $display("FAIL late_err_count got=%0d want=1", err_count); end
        strobes = 0;
        repeat (60) step(1'b0);
        total++; if (strobes != 0 || err_count !== 16'd1) begin bad++; $display("FAIL late_idle_quiet got=%0d/%0d want=0/1", strobes, err_count); end
    endtask

    task automatic test_acq_pattern();
        int ivs[6] = '{22, 22, 21, 22, 22, 22};
        logic [5:0] exp_lk = 6'b100000;
        do_reset();
        step(1'b1);
        for (int i = 0; i < 6; i++) begin
            repeat (ivs[i]-1) step(1'b0);
            period(1, 1);
            total++; if (snap_lk !== exp_lk[i] || snap_lp !== 6'(ivs[i])) begin
                bad++; $display("FAIL acq_iv%0d got=%0d/%0d want=%0d/%0d", i, snap_lk, snap_lp, exp_lk[i], ivs[i]);
            end
        end
        total++; if (strobes != 0) begin bad++; $display("FAIL acq_no_strobes got=%0d want=0", strobes); end
    endtask

    task automatic test_wide();
        do_reset();
        repeat (3) period(5, 22);
        total++; if (snap_lk !== 1'b0) begin bad++; $display("FAIL wide_early_lock got=%0d want=0", snap_lk); end
        period(5, 22);
        total++; if (snap_lk !== 1'b1 || snap_lp !== 6'd22) begin bad++; $display("FAIL wide_lock got=%0d/%0d want=1/22", snap_lk, snap_lp); end
        period(5, 22);
        total++; if (locked !== 1'b1 || strobes != 0) begin bad++; $display("FAIL wide_hold got=%0d/%0d want=1/0", locked, strobes); end
    endtask

    task automatic test_reset_edge();
        lock_up();
        repeat (19) step(1'b0);
        step(1'b1);
        repeat (21) step(1'b0);
        repeat (3) period(1, 22);
        step(1'b1);
        total++; if (locked !== 1'b1 || err_count !== 16'd1) begin bad++; $display("FAIL rstedge_pre got=%0d/%0d want=1/1", locked, err_count); end
        repeat (21) step(1'b0);
        rst = 1'b1;
        step(1'b1);
        rst = 1'b0;
        total++; if ({locked, err_early, err_late} !== 3'b000) begin bad++; $display("FAIL rstedge_flags got=%b want=000", {locked, err_early, err_late}); end
        total++; if (err_count !== 16'd0 || last_period !== 6'd0) begin bad++; $display("FAIL rstedge_regs got=%0d/%0d want=0/0", err_count, last_period); end
        strobes = 0;
        repeat (50) step(1'b0);
        total++; if (strobes != 0 || locked !== 1'b0) begin bad++; $display("FAIL rstedge_idle got=%0d/%0d want=0/0", strobes, locked); end
    endtask

`ifdef PULSE_CHK_TOLERANCE_EN
    task automatic test_tolerance();
        lock_up();
        repeat (22) step(1'b0);
        period(1, 1);
        total++; if (snap_lk !== 1'b1 || snap_lp !== 6'd23) begin bad++; $display("FAIL tol_23 got=%0d/%0d want=1/23", snap_lk, snap_lp); end
        repeat (20) step(1'b0);
        period(1, 1);
        total++; if (snap_lk !== 1'b1 || snap_lp !== 6'd21) begin bad++; $display("FAIL tol_21 got=%0d/%0d want=1/21", snap_lk, snap_lp); end
        repeat (21) step(1'b0);
        period(1, 1);
        total++; if (snap_lk !== 1'b1 || snap_lp !== 6'd22) begin bad++; $display("FAIL tol_22 got=%0d/%0d want=1/22", snap_lk, snap_lp); end
        repeat (19) step(1'b0);
        period(1, 1);
        total++; if (snap_ee !== 1'b1 || snap_lk !== 1'b0) begin bad++; $display("FAIL tol_20 got=%0d/%0d want=1/0", snap_ee, snap_lk); end
    endtask
`endif

    initial begin
        test_reset();
        test_lock();
        test_early();
        test_late();
        test_acq_pattern();
        test_wide();
        test_reset_edge();
`ifdef PULSE_CHK_TOLERANCE_EN
        test_tolerance();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
